// File: rtl/vx_commit_gen_if.sv
// Commit-stage bus: execution-unit results in, lane-group commit beats out.
// The slave modport is the commit generator; the master modport is its environment.
interface vx_commit_gen_if #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 44
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [UUID_WIDTH-1:0]       in_uuid;
  logic [NW_WIDTH-1:0]         in_wid;
  logic [XLEN-1:0]             in_PC;
  logic                        in_wb;
  logic [NR_BITS-1:0]          in_rd;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [NUM_THREADS*XLEN-1:0] in_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [UUID_WIDTH-1:0]       out_uuid;
  logic [NW_WIDTH-1:0]         out_wid;
  logic [XLEN-1:0]             out_PC;
  logic                        out_wb;
  logic [NR_BITS-1:0]          out_rd;
  logic [NUM_LANES-1:0]        out_tmask;
  logic [NUM_LANES*XLEN-1:0]   out_data;
  logic [PID_WIDTH-1:0]        out_pid;
  logic                        out_sop;
  logic                        out_eop;

  modport master (
    output in_valid, in_uuid, in_wid, in_PC, in_wb, in_rd, in_tmask, in_data, out_ready,
    input  in_ready, out_valid, out_uuid, out_wid, out_PC, out_wb, out_rd,
           out_tmask, out_data, out_pid, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_PC, in_wb, in_rd, in_tmask, in_data, out_ready,
    output in_ready, out_valid, out_uuid, out_wid, out_PC, out_wb, out_rd,
           out_tmask, out_data, out_pid, out_sop, out_eop
  );
endinterface

// File: rtl/vx_commit_gen.sv
// Buffers warp results in a small FIFO and splits the head entry into one commit
// beat per active lane group, skipping groups whose thread mask slice is empty.
module vx_commit_gen #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 44,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
  localparam int AW          = $clog2(DEPTH),
  localparam int CNT_WIDTH   = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_commit_gen_if.slave       io_bus,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [UUID_WIDTH-1:0]       r_uuid  [DEPTH];
  logic [NW_WIDTH-1:0]         r_wid   [DEPTH];
  logic [XLEN-1:0]             r_pc    [DEPTH];
  logic                        r_wb    [DEPTH];
  logic [NR_BITS-1:0]          r_rd    [DEPTH];
  logic [NUM_THREADS-1:0]      r_tmask [DEPTH];
  logic [NUM_THREADS*XLEN-1:0] r_data  [DEPTH];

  logic [AW-1:0]               r_wrPtr;
  logic [AW-1:0]               r_rdPtr;
  logic [CNT_WIDTH-1:0]        r_count;
  logic [NUM_PACKETS-1:0]      r_doneMask;

  logic [NUM_THREADS-1:0]      w_headTmask;
  logic [NUM_THREADS*XLEN-1:0] w_headData;
  logic [NUM_PACKETS-1:0]      w_groupActive;
  logic [NUM_PACKETS-1:0]      w_pending;
  logic [NUM_PACKETS-1:0]      w_curOnehot;
  logic [PID_WIDTH-1:0]        w_curPid;
  logic                        w_isLast;
  logic                        w_push;
  logic                        w_fire;
  logic                        w_pop;

  assign w_headTmask = r_tmask[r_rdPtr];
  assign w_headData  = r_data[r_rdPtr];

  assign io_bus.in_ready  = (r_count < CNT_WIDTH'(DEPTH));
  assign io_bus.out_valid = (r_count != '0);

  assign w_push = io_bus.in_valid && io_bus.in_ready;
  assign w_fire = io_bus.out_valid && io_bus.out_ready;
  assign w_pop  = w_fire && w_isLast;

  always_comb begin
    w_groupActive = '0;
    for (int g = 0; g < NUM_PACKETS; g++) begin
      w_groupActive[g] = |w_headTmask[g*NUM_LANES +: NUM_LANES];
    end
  end

  assign w_pending = w_groupActive & ~r_doneMask;

  // Lowest pending group is the current beat; an all-zero mask falls back to group 0.
  always_comb begin
    w_curOnehot = '0;
    w_curPid    = '0;
    for (int g = NUM_PACKETS - 1; g >= 0; g--) begin
      if (w_pending[g]) begin
        w_curOnehot    = '0;
        w_curOnehot[g] = 1'b1;
        w_curPid       = PID_WIDTH'(g);
      end
    end
  end

  assign w_isLast = ((w_pending & ~w_curOnehot) == '0);

  always_comb begin
    io_bus.out_tmask = w_headTmask[0 +: NUM_LANES];
    io_bus.out_data  = w_headData[0 +: NUM_LANES*XLEN];
    for (int g = 0; g < NUM_PACKETS; g++) begin
      if (w_curOnehot[g]) begin
        io_bus.out_tmask = w_headTmask[g*NUM_LANES +: NUM_LANES];
        io_bus.out_data  = w_headData[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end
  end

  assign io_bus.out_pid  = w_curPid;
  assign io_bus.out_sop  = (r_doneMask == '0);
  assign io_bus.out_eop  = w_isLast;
  assign io_bus.out_uuid = r_uuid[r_rdPtr];
  assign io_bus.out_wid  = r_wid[r_rdPtr];
  assign io_bus.out_PC   = r_pc[r_rdPtr];
  assign io_bus.out_wb   = r_wb[r_rdPtr];
  assign io_bus.out_rd   = r_rd[r_rdPtr];
  assign o_count         = r_count;

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_uuid[r_wrPtr]  <= io_bus.in_uuid;
      r_wid[r_wrPtr]   <= io_bus.in_wid;
      r_pc[r_wrPtr]    <= io_bus.in_PC;
      r_wb[r_wrPtr]    <= io_bus.in_wb;
      r_rd[r_wrPtr]    <= io_bus.in_rd;
      r_tmask[r_wrPtr] <= io_bus.in_tmask;
      r_data[r_wrPtr]  <= io_bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_doneMask <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + AW'(1);
        r_doneMask <= '0;
      end else if (w_fire) begin
        r_doneMask <= r_doneMask | w_curOnehot;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vx_commit_gen.sv
// Randomized and directed bench for vx_commit_gen against a beat-queue reference
// model that expands every accepted result into its expected commit beats.
module tb_vx_commit_gen;

  localparam int NT    = 4;
  localparam int NL    = 2;
  localparam int DEPTH = 4;
  localparam int XL    = 32;
  localparam int NWW   = 2;
  localparam int NRB   = 6;
  localparam int UW    = 44;
  localparam int NP    = NT / NL;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [UW-1:0]    uuid;
    logic [NWW-1:0]   wid;
    logic [XL-1:0]    pc;
    logic             wb;
    logic [NRB-1:0]   rd;
    int               pid;
    logic [NL-1:0]    tmask;
    logic [NL*XL-1:0] data;
    logic             sop;
    logic             eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] count;

  beat_t expQ[$];
  int    modelCount = 0;
  int    assertCount = 0;
  int    failCount = 0;

  always #5 clk = ~clk;

  vx_commit_gen_if #(
    .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL),
    .NW_WIDTH(NWW), .NR_BITS(NRB), .UUID_WIDTH(UW)
  ) bus ();

  vx_commit_gen #(
    .NUM_THREADS(NT), .NUM_LANES(NL), .DEPTH(DEPTH), .XLEN(XL),
    .NW_WIDTH(NWW), .NR_BITS(NRB), .UUID_WIDTH(UW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_bus  (bus),
    .o_count (count)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NT*XL-1:0] randData();
    logic [NT*XL-1:0] d;
    for (int i = 0; i < NT; i++) d[i*XL +: XL] = $urandom;
    return d;
  endfunction

  // Expected beats: one per non-empty lane group in ascending order, or a single empty beat.
  task automatic pushEntry();
    beat_t b;
    beat_t tmp[$];
    b.uuid = bus.in_uuid;
    b.wid  = bus.in_wid;
    b.pc   = bus.in_PC;
    b.wb   = bus.in_wb;
    b.rd   = bus.in_rd;
    b.sop  = 1'b0;
    b.eop  = 1'b0;
    for (int g = 0; g < NP; g++) begin
      if (bus.in_tmask[g*NL +: NL] != '0) begin
        b.pid   = g;
        b.tmask = bus.in_tmask[g*NL +: NL];
        b.data  = bus.in_data[g*NL*XL +: NL*XL];
        tmp.push_back(b);
      end
    end
    if (tmp.size() == 0) begin
      b.pid   = 0;
      b.tmask = '0;
      b.data  = '0;
      tmp.push_back(b);
    end
    tmp[0].sop = 1'b1;
    tmp[tmp.size()-1].eop = 1'b1;
    foreach (tmp[i]) expQ.push_back(tmp[i]);
  endtask

  task automatic compareToModel();
    beat_t b;
    checkOutput("count", 128'(count), 128'(modelCount));
    checkOutput("in_ready", 128'(bus.in_ready), 128'(modelCount < DEPTH));
    checkOutput("out_valid", 128'(bus.out_valid), 128'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      b = expQ[0];
      checkOutput("out_pid", 128'(bus.out_pid), 128'(b.pid));
      checkOutput("out_tmask", 128'(bus.out_tmask), 128'(b.tmask));
      checkOutput("out_sop", 128'(bus.out_sop), 128'(b.sop));
      checkOutput("out_eop", 128'(bus.out_eop), 128'(b.eop));
      checkOutput("out_uuid", 128'(bus.out_uuid), 128'(b.uuid));
      checkOutput("out_hdr", 128'({bus.out_wid, bus.out_PC, bus.out_wb, bus.out_rd}),
                  128'({b.wid, b.pc, b.wb, b.rd}));
      if (b.tmask != '0) checkOutput("out_data", 128'(bus.out_data), 128'(b.data));
    end
  endtask

  // Drive one cycle at the falling edge, check the state seen there, then advance the model.
  task automatic applyStimulus(input logic valid, input logic [NT-1:0] tmask,
                               input logic [NT*XL-1:0] data, input logic ordy);
    logic accept;
    logic fire;
    beat_t b;
    @(negedge clk);
    bus.in_valid  = valid;
    bus.in_tmask  = tmask;
    bus.in_data   = data;
    bus.in_uuid   = UW'({$urandom, $urandom});
    bus.in_wid    = NWW'($urandom);
    bus.in_PC     = $urandom;
    bus.in_wb     = 1'($urandom);
    bus.in_rd     = NRB'($urandom);
    bus.out_ready = ordy;
    compareToModel();
    accept = valid && (modelCount < DEPTH);
    fire   = ordy && (expQ.size() != 0);
    if (fire) begin
      b = expQ.pop_front();
      if (b.eop) modelCount--;
    end
    if (accept) begin
      pushEntry();
      modelCount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    modelCount = 0;
  endtask

  localparam logic [XL-1:0] D0 = 32'h1000_00a0;
  localparam logic [XL-1:0] D1 = 32'h2000_00b1;
  localparam logic [XL-1:0] D2 = 32'h3000_00c2;
  localparam logic [XL-1:0] D3 = 32'h4000_00d3;

  initial begin
    logic [NT*XL-1:0] dvec;
    logic [NT-1:0]    fillMasks [4];
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_tmask  = '0;
    bus.in_data   = '0;
    bus.in_uuid   = '0;
    bus.in_wid    = '0;
    bus.in_PC     = '0;
    bus.in_wb     = 1'b0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;
    dvec = {D3, D2, D1, D0};
    fillMasks[0] = 4'b1111;
    fillMasks[1] = 4'b0011;
    fillMasks[2] = 4'b0000;
    fillMasks[3] = 4'b1100;

    doReset();
    #1;
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(bus.in_ready), 128'(1));
    checkOutput("rst_count", 128'(count), 128'(0));

    // Full mask entry splits into two beats, low group first.
    applyStimulus(1'b1, 4'b1111, dvec, 1'b1);
    checkOutput("b1_pid", 128'(bus.out_pid), 128'(0));
    checkOutput("b1_tmask", 128'(bus.out_tmask), 128'(2'b11));
    checkOutput("b1_data", 128'(bus.out_data), 128'({D1, D0}));
    checkOutput("b1_sop_eop", 128'({bus.out_sop, bus.out_eop}), 128'(2'b10));
    checkOutput("b1_count", 128'(count), 128'(1));
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("b2_pid", 128'(bus.out_pid), 128'(1));
    checkOutput("b2_data", 128'(bus.out_data), 128'({D3, D2}));
    checkOutput("b2_sop_eop", 128'({bus.out_sop, bus.out_eop}), 128'(2'b01));
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("b2_drained", 128'(count), 128'(0));

    // Upper-group-only and empty masks each yield a single beat.
    applyStimulus(1'b1, 4'b1100, dvec, 1'b1);
    checkOutput("hi_pid", 128'(bus.out_pid), 128'(1));
    checkOutput("hi_sop_eop", 128'({bus.out_sop, bus.out_eop}), 128'(2'b11));
    applyStimulus(1'b1, 4'b0000, dvec, 1'b1);
    checkOutput("zero_pid", 128'(bus.out_pid), 128'(0));
    checkOutput("zero_tmask", 128'(bus.out_tmask), 128'(0));
    checkOutput("zero_sop_eop", 128'({bus.out_sop, bus.out_eop}), 128'(2'b11));
    applyStimulus(1'b0, '0, '0, 1'b1);

    // Stall on the first beat, then release.
    applyStimulus(1'b1, 4'b1111, randData(), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("stall_next_pid", 128'(bus.out_pid), 128'(1));
    applyStimulus(1'b0, '0, '0, 1'b1);

    // Fill to capacity, attempt an extra push, then drain back-to-back.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fillMasks[i], randData(), 1'b0);
    checkOutput("full_count", 128'(count), 128'(4));
    checkOutput("full_in_ready", 128'(bus.in_ready), 128'(0));
    applyStimulus(1'b1, 4'b1111, randData(), 1'b0);
    checkOutput("full_refused", 128'(count), 128'(4));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("drain_count", 128'(count), 128'(0));

    // Reset in the middle of a two-beat entry.
    applyStimulus(1'b1, 4'b1111, randData(), 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    doReset();
    #1;
    checkOutput("midrst_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("midrst_count", 128'(count), 128'(0));
    applyStimulus(1'b1, 4'b1100, randData(), 1'b0);
    checkOutput("midrst_pid", 128'(bus.out_pid), 128'(1));
    checkOutput("midrst_sop", 128'(bus.out_sop), 128'(1));
    applyStimulus(1'b0, '0, '0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) doReset();
      applyStimulus($urandom_range(0, 99) < 60, NT'($urandom), randData(),
                    $urandom_range(0, 99) < 70);
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("final_count", 128'(count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
